// File: rtl/transform_pkg.sv
// Shared defaults and FSM state encoding for the transform scheduler and its raster counter.
package transform_pkg;

  localparam int DEF_XW   = 11;
  localparam int DEF_YW   = 10;
  localparam int DEF_CVW  = 13;
  localparam int DEF_LAT  = 4;
  localparam int DEF_FB_W = 1024;
  localparam int DEF_FB_H = 768;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } sched_state_t;

endpackage

// File: rtl/raster_counter.sv
// Template raster position (x fastest) with synchronous clear/step and last-pixel detect.
module raster_counter
  import transform_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          step,
  input  logic [XW-1:0] width,
  input  logic [YW-1:0] height,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic x_at_end;

  assign x_at_end = (x == width - XW'(1));
  assign last     = x_at_end && (y == height - YW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (x_at_end) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/transform_scheduler.sv
// Raster-scans a template, issues one transform per pixel and streams (template, camera) coordinate pairs.
// Define TRANSFORM_SCHED_CLIP_EN to drop results that land outside the FB_W x FB_H camera frame.
module transform_scheduler
  import transform_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int CVW  = DEF_CVW,
  parameter int LAT  = DEF_LAT,
  parameter int FB_W = DEF_FB_W,
  parameter int FB_H = DEF_FB_H
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           go,
  input  logic [XW-1:0]  t_width,
  input  logic [YW-1:0]  t_height,
  output logic           busy,
  output logic           done,
  output logic           tf_start,
  output logic [XW-1:0]  tf_x,
  output logic [YW-1:0]  tf_y,
  input  logic [CVW-1:0] tf_cv_x,
  input  logic [CVW-1:0] tf_cv_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [XW-1:0]  out_x,
  output logic [YW-1:0]  out_y,
  output logic [CVW-1:0] out_cv_x,
  output logic [CVW-1:0] out_cv_y,
  output logic           out_offframe
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  function automatic logic is_offframe(input logic [CVW-1:0] cx, input logic [CVW-1:0] cy);
    return (cx >= CVW'(FB_W)) || (cy >= CVW'(FB_H));
  endfunction

  sched_state_t   state, state_nxt;
  logic [XW-1:0]  w_lat;
  logic [YW-1:0]  h_lat;
  logic [WCW-1:0] wcnt;
  logic [CVW-1:0] cv_x_q, cv_y_q;
  logic           off_q;
  logic           cnt_clear, cnt_step;
  logic [XW-1:0]  cur_x;
  logic [YW-1:0]  cur_y;
  logic           cur_last;
  logic           wait_done, off_now;

  assign wait_done = (state == S_WAIT) && (wcnt == WCW'(LAT - 1));
  assign off_now   = is_offframe(tf_cv_x, tf_cv_y);

  raster_counter #(.XW(XW), .YW(YW)) u_raster (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (cnt_clear),
    .step   (cnt_step),
    .width  (w_lat),
    .height (h_lat),
    .x      (cur_x),
    .y      (cur_y),
    .last   (cur_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      w_lat  <= '0;
      h_lat  <= '0;
      wcnt   <= '0;
      cv_x_q <= '0;
      cv_y_q <= '0;
      off_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && go) begin
        w_lat <= t_width;
        h_lat <= t_height;
      end
      if (state == S_ISSUE)     wcnt <= '0;
      else if (state == S_WAIT) wcnt <= wcnt + WCW'(1);
      // Transform output is valid on the last WAIT cycle; capture it on that edge.
      if (wait_done) begin
        cv_x_q <= tf_cv_x;
        cv_y_q <= tf_cv_y;
`ifdef TRANSFORM_SCHED_CLIP_EN
        off_q  <= 1'b0;
`else
        off_q  <= off_now;
`endif
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          cnt_clear = 1'b1;
          state_nxt = (t_width == '0 || t_height == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_done) begin
`ifdef TRANSFORM_SCHED_CLIP_EN
          state_nxt = off_now ? S_NEXT : S_EMIT;
`else
          state_nxt = S_EMIT;
`endif
        end
      end
      S_EMIT:  if (out_ready) state_nxt = S_NEXT;
      S_NEXT: begin
        if (cur_last) begin
          state_nxt = S_FIN;
        end else begin
          cnt_step  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy         = (state == S_ISSUE) || (state == S_WAIT) ||
                        (state == S_EMIT)  || (state == S_NEXT);
  assign done         = (state == S_FIN);
  assign tf_start     = (state == S_ISSUE);
  assign tf_x         = cur_x;
  assign tf_y         = cur_y;
  assign out_valid    = (state == S_EMIT);
  assign out_x        = cur_x;
  assign out_y        = cur_y;
  assign out_cv_x     = cv_x_q;
  assign out_cv_y     = cv_y_q;
  assign out_offframe = off_q;

endmodule
